// File: rtl/game_state_ctrl.sv
// ---------------------------------------------------------------------------
// game_state_ctrl
//
// Frame-synchronous game-state sequencer. Button and gameplay events are
// collected at any time, but game_state only changes in the cycle after a
// vblnk rising edge, so the overlay drawers never see a state change
// mid-frame.
//
// Ports
//   clk          in   pixel clock
//   rst          in   asynchronous, active-high reset
//   vblnk        in   vertical blank from the VGA timing chain
//   start_btn    in   raw start button (asynchronous, active-high)
//   pause_btn    in   raw pause button (asynchronous, active-high)
//   player_dead  in   level from game logic, sampled on frame_tick
//   wave_clear   in   level from game logic, sampled on frame_tick
//   game_state   out  000 MENU, 001 PLAY, 010 PAUSE, 011 WIN, 100 OVER
//   frame_tick   out  one-cycle pulse after each vblnk rising edge
//   game_rst     out  one-cycle pulse when PLAY is entered from MENU/WIN/OVER
// ---------------------------------------------------------------------------
module game_state_ctrl #(
   parameter int OVER_FRAMES    = 300,
   parameter int LOCKOUT_FRAMES = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vblnk,
   input  logic       start_btn,
   input  logic       pause_btn,
   input  logic       player_dead,
   input  logic       wave_clear,
   output logic [2:0] game_state,
   output logic       frame_tick,
   output logic       game_rst
);

   localparam int CNT_W = $clog2(OVER_FRAMES + 1);
   localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCKOUT_FRAMES);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVER_FRAMES - 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(OVER_FRAMES);

   typedef enum logic [2:0] {
      ST_MENU  = 3'b000,
      ST_PLAY  = 3'b001,
      ST_PAUSE = 3'b010,
      ST_WIN   = 3'b011,
      ST_OVER  = 3'b100
   } state_e;

   // Button synchronisers, edge-detect history and registered pulses
   logic start_s1_q, start_s1_d, start_s2_q, start_s2_d;
   logic start_e_q,  start_e_d,  start_p_q,  start_p_d;
   logic pause_s1_q, pause_s1_d, pause_s2_q, pause_s2_d;
   logic pause_e_q,  pause_e_d,  pause_p_q,  pause_p_d;

   // Frame tick generation
   logic vblnk_dly_q, vblnk_dly_d;
   logic armed_q, armed_d;
   logic frame_tick_q, frame_tick_d;

   // Pending events and state
   logic             start_pend_q, start_pend_d;
   logic             pause_pend_q, pause_pend_d;
   // Plain vector rather than state_e: it must be able to hold the illegal
   // encodings 101..111 so that they can be recovered from.
   logic [2:0]       game_state_q, game_state_d;
   logic             game_rst_q, game_rst_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   // NOTE: every signal gets a default at the top of the block, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      start_s1_d   = start_btn;
      start_s2_d   = start_s1_q;
      start_e_d    = start_s2_q;
      start_p_d    = start_s2_q & ~start_e_q;
      pause_s1_d   = pause_btn;
      pause_s2_d   = pause_s1_q;
      pause_e_d    = pause_s2_q;
      pause_p_d    = pause_s2_q & ~pause_e_q;

      vblnk_dly_d  = vblnk;
      // A tick needs vblnk to have been seen low since reset, so vblnk held
      // high across reset release does not produce a spurious tick.
      armed_d      = armed_q | ~vblnk;
      frame_tick_d = vblnk & ~vblnk_dly_q & armed_q;

      // On a tick the old flag is consumed; a pulse landing in that very
      // cycle is kept for the next frame.
      start_pend_d = frame_tick_q ? start_p_q : (start_pend_q | start_p_q);
      pause_pend_d = frame_tick_q ? pause_p_q : (pause_pend_q | pause_p_q);

      game_state_d = game_state_q;
      game_rst_d   = 1'b0;
      frame_cnt_d  = frame_cnt_q;

      if (frame_tick_q) begin
         case (game_state_q)
            ST_MENU: begin
               if (start_pend_q) begin
                  game_state_d = ST_PLAY;
                  game_rst_d   = 1'b1;
               end
            end
            ST_PLAY: begin
               if (player_dead) begin
                  game_state_d = ST_OVER;
                  frame_cnt_d  = '0;
               end else if (wave_clear) begin
                  game_state_d = ST_WIN;
                  frame_cnt_d  = '0;
               end else if (pause_pend_q) begin
                  game_state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (pause_pend_q || start_pend_q) begin
                  game_state_d = ST_PLAY;
               end
            end
            ST_WIN, ST_OVER: begin
               // Restart takes precedence over the timeout on the same tick.
               if ((frame_cnt_q >= LOCK_CNT) && start_pend_q) begin
                  game_state_d = ST_PLAY;
                  game_rst_d   = 1'b1;
               end else if (frame_cnt_q == LAST_CNT) begin
                  game_state_d = ST_MENU;
               end
               frame_cnt_d = (frame_cnt_q == MAX_CNT) ? frame_cnt_q
                                                      : frame_cnt_q + 1'b1;
            end
            default: game_state_d = ST_MENU;
         endcase
      end
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // flop samples the pre-edge value of the others regardless of order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_s1_q   <= 1'b0;
         start_s2_q   <= 1'b0;
         start_e_q    <= 1'b0;
         start_p_q    <= 1'b0;
         pause_s1_q   <= 1'b0;
         pause_s2_q   <= 1'b0;
         pause_e_q    <= 1'b0;
         pause_p_q    <= 1'b0;
         vblnk_dly_q  <= 1'b0;
         armed_q      <= 1'b0;
         frame_tick_q <= 1'b0;
         start_pend_q <= 1'b0;
         pause_pend_q <= 1'b0;
         game_state_q <= ST_MENU;
         game_rst_q   <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         start_s1_q   <= start_s1_d;
         start_s2_q   <= start_s2_d;
         start_e_q    <= start_e_d;
         start_p_q    <= start_p_d;
         pause_s1_q   <= pause_s1_d;
         pause_s2_q   <= pause_s2_d;
         pause_e_q    <= pause_e_d;
         pause_p_q    <= pause_p_d;
         vblnk_dly_q  <= vblnk_dly_d;
         armed_q      <= armed_d;
         frame_tick_q <= frame_tick_d;
         start_pend_q <= start_pend_d;
         pause_pend_q <= pause_pend_d;
         game_state_q <= game_state_d;
         game_rst_q   <= game_rst_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign game_state = game_state_q;
   assign frame_tick = frame_tick_q;
   assign game_rst   = game_rst_q;

endmodule
